// File: rtl/barrel_shift_pipe8_if.sv
// Bus bundle for the pipelined barrel shifter.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. A source holds valid and its payload steady until that edge.
// The ready signals may depend combinationally on the downstream ready.
// flush is a synchronous control: at an edge where it is 1, every
// operation held in the pipeline is dropped. An input transfer at that
// same edge is also discarded.
interface barrel_shift_pipe8_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Side that issues operations and consumes results.
    modport master (
        output flush, in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The shifter pipeline itself.
    modport slave (
        input  flush, in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/barrel_shift_pipe8.sv
// Pipelined barrel shifter with valid/ready on both sides.
// There is one stage per shift-amount bit. Stage s shifts by 2**s when its
// shamt bit s is set. Each stage is a per-bit 4:1 select on mode:
//   00 SRL, 01 SRA, 10 SLL, 11 ROL.
// The SRA fill bit is the operand's original MSB. It is captured at entry
// and carried down the pipe beside the data.
// The ready chain is purely combinational. A full pipe still accepts a new
// operation in the same cycle that its oldest result retires.
module barrel_shift_pipe8 #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    barrel_shift_pipe8_if.slave   bus
);

    // Stage registers
    logic [SHW-1:0]   r_v;
    logic [SHW-1:0]   r_sign;
    logic [WIDTH-1:0] r_data  [SHW];
    logic [SHW-1:0]   r_shamt [SHW];
    logic [1:0]       r_mode  [SHW];

    // Per-stage inputs (previous stage, or the bus for stage 0)
    logic [SHW-1:0]   w_src_v;
    logic [SHW-1:0]   w_src_sign;
    logic [WIDTH-1:0] w_src_data  [SHW];
    logic [SHW-1:0]   w_src_shamt [SHW];
    logic [1:0]       w_src_mode  [SHW];

    // Per-stage shifted result and load enable
    logic [WIDTH-1:0] w_res_data [SHW];
    logic [SHW-1:0]   w_load;

    // Stage inputs: stage 0 sees the bus, later stages see their predecessor.
    for (genvar s = 0; s < SHW; s++) begin : g_src
        if (s == 0) begin : g_first
            assign w_src_v[s]     = bus.in_valid;
            assign w_src_sign[s]  = bus.in_data[WIDTH-1];
            assign w_src_data[s]  = bus.in_data;
            assign w_src_shamt[s] = bus.in_shamt;
            assign w_src_mode[s]  = bus.in_mode;
        end else begin : g_next
            assign w_src_v[s]     = r_v[s-1];
            assign w_src_sign[s]  = r_sign[s-1];
            assign w_src_data[s]  = r_data[s-1];
            assign w_src_shamt[s] = r_shamt[s-1];
            assign w_src_mode[s]  = r_mode[s-1];
        end
    end

    // Shift network: each output bit picks among four candidates by mode.
    for (genvar s = 0; s < SHW; s++) begin : g_shift
        localparam int D = 1 << s;
        logic [WIDTH-1:0] w_shifted;

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [3:0] w_cand;

            // Right shifts pull from higher bits.
            // Past the MSB they fill with zero (SRL) or the sign (SRA).
            if (i + D < WIDTH) begin : g_rin
                assign w_cand[0] = w_src_data[s][i + D];
                assign w_cand[1] = w_src_data[s][i + D];
            end else begin : g_rfill
                assign w_cand[0] = 1'b0;
                assign w_cand[1] = w_src_sign[s];
            end

            // Left shift pulls from lower bits, zero fill below bit D.
            if (i >= D) begin : g_lin
                assign w_cand[2] = w_src_data[s][i - D];
            end else begin : g_lfill
                assign w_cand[2] = 1'b0;
            end

            // Rotate left wraps the top bits around to the bottom.
            assign w_cand[3] = w_src_data[s][(i - D + WIDTH) % WIDTH];

            assign w_shifted[i] = w_cand[w_src_mode[s]];
        end

        assign w_res_data[s] = w_src_shamt[s][s] ? w_shifted : w_src_data[s];
    end

    // Ready chain: a stage may load when it is empty or the stage after it
    // loads this cycle. The last stage loads when it is empty or its result
    // retires downstream.
    always_comb begin
        w_load          = '0;
        w_load[SHW-1]   = bus.out_ready | ~r_v[SHW-1];
        for (int s = SHW - 2; s >= 0; s--) begin
            w_load[s] = ~r_v[s] | w_load[s+1];
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_v[SHW-1];
    assign bus.out_data  = r_data[SHW-1];

    // Stage registers: advance on load, hold otherwise.
    // Flush drops every valid bit. Payload follows only real operations,
    // so bubbles leave the previous result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_sign <= '0;
            for (int s = 0; s < SHW; s++) begin
                r_data[s]  <= '0;
                r_shamt[s] <= '0;
                r_mode[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < SHW; s++) begin
                if (bus.flush) begin
                    r_v[s] <= 1'b0;
                end else if (w_load[s]) begin
                    r_v[s] <= w_src_v[s];
                end
                if (w_load[s] && w_src_v[s]) begin
                    r_data[s]  <= w_res_data[s];
                    r_shamt[s] <= w_src_shamt[s];
                    r_mode[s]  <= w_src_mode[s];
                    r_sign[s]  <= w_src_sign[s];
                end
            end
        end
    end

    // The last stage's control fields and the already-consumed shamt bits
    // have no reader. They are kept so every stage holds the same record.
    logic w_unused_fields;
    always_comb begin
        w_unused_fields = r_sign[SHW-1] ^ (^r_mode[SHW-1]);
        for (int s = 0; s < SHW; s++) begin
            w_unused_fields = w_unused_fields ^ (^r_shamt[s]);
        end
    end

endmodule
